// File: rtl/fft_frame_collector.sv
// Collects decimated audio samples into 16-sample frames and double-buffers them for a downstream FFT.
// Optional 50% frame overlap is enabled by defining FRAME_OVERLAP_EN.
module fft_frame_collector #(
    parameter int DECIM = 1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic signed [23:0] sample_in,
    input  logic               sample_valid,
    input  logic               frame_ack,
    output logic signed [23:0] s0,
    output logic signed [23:0] s1,
    output logic signed [23:0] s2,
    output logic signed [23:0] s3,
    output logic signed [23:0] s4,
    output logic signed [23:0] s5,
    output logic signed [23:0] s6,
    output logic signed [23:0] s7,
    output logic signed [23:0] s8,
    output logic signed [23:0] s9,
    output logic signed [23:0] s10,
    output logic signed [23:0] s11,
    output logic signed [23:0] s12,
    output logic signed [23:0] s13,
    output logic signed [23:0] s14,
    output logic signed [23:0] s15,
    output logic               frame_valid,
    output logic [4:0]         fill_count,
    output logic               overrun
);
    localparam int DATA_W = 24;
    localparam int SLOTS  = 16;
`ifdef FRAME_OVERLAP_EN
    localparam logic [4:0] RESTART = 5'd8;
`else
    localparam logic [4:0] RESTART = 5'd0;
`endif

    typedef enum logic {FILL, HOLD} state_t;

    state_t                   state, state_nxt;
    logic [3:0]               dcnt;
    logic                     accept, transfer;
    logic [4:0]               fill_nxt;
    logic                     fv_nxt, ovr_nxt;
    logic [3:0]               wr_slot;
    logic signed [DATA_W-1:0] fill_buf [SLOTS];
    logic signed [DATA_W-1:0] out_bank [SLOTS];

    assign accept   = sample_valid && (dcnt == 4'd0);
    assign transfer = (state == HOLD) && (!frame_valid || frame_ack);
    // A sample landing on the transfer edge starts the next frame at the restart slot.
    assign wr_slot  = transfer ? RESTART[3:0] : fill_count[3:0];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= FILL;
            fill_count  <= 5'd0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_nxt;
            fill_count  <= fill_nxt;
            frame_valid <= fv_nxt;
            overrun     <= ovr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fill_nxt  = fill_count;
        fv_nxt    = frame_valid;
        ovr_nxt   = overrun;
        unique case (state)
            FILL: begin
                if (accept) begin
                    fill_nxt = fill_count + 5'd1;
                    if (fill_count == 5'd15)
                        state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (transfer) begin
                    state_nxt = FILL;
                    fill_nxt  = RESTART + {4'd0, accept};
                end else if (accept) begin
                    ovr_nxt = 1'b1;
                end
            end
        endcase
        if (transfer)
            fv_nxt = 1'b1;
        else if (frame_ack)
            fv_nxt = 1'b0;
    end

    // The counter keeps running in HOLD so the decimation phase never slips.
    always_ff @(posedge Clk) begin
        if (Reset)
            dcnt <= 4'd0;
        else if (sample_valid)
            dcnt <= (dcnt == 4'(DECIM - 1)) ? 4'd0 : dcnt + 4'd1;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < SLOTS; i++) begin
                fill_buf[i] <= '0;
                out_bank[i] <= '0;
            end
        end else begin
            if (transfer) begin
                for (int i = 0; i < SLOTS; i++)
                    out_bank[i] <= fill_buf[i];
`ifdef FRAME_OVERLAP_EN
                for (int i = 0; i < SLOTS / 2; i++)
                    fill_buf[i] <= fill_buf[i + SLOTS / 2];
`endif
            end
            if (accept && (state == FILL || transfer))
                fill_buf[wr_slot] <= sample_in;
        end
    end

    assign s0  = out_bank[0];
    assign s1  = out_bank[1];
    assign s2  = out_bank[2];
    assign s3  = out_bank[3];
    assign s4  = out_bank[4];
    assign s5  = out_bank[5];
    assign s6  = out_bank[6];
    assign s7  = out_bank[7];
    assign s8  = out_bank[8];
    assign s9  = out_bank[9];
    assign s10 = out_bank[10];
    assign s11 = out_bank[11];
    assign s12 = out_bank[12];
    assign s13 = out_bank[13];
    assign s14 = out_bank[14];
    assign s15 = out_bank[15];
endmodule
